seq_multiplier: RTL

//   Parametrised iterative shift-add multiplier for the multi-cycle CPU datapath.

---
 rtl/seq_multiplier.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned,
// one partial-product row per clock under a start/busy/done handshake.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] a_mag, b_mag;

  // Operand magnitudes; the most negative value maps to unsigned 2^(WIDTH-1).
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (is_signed && a[WIDTH-1]) a_mag = WIDTH'(-a);
    if (is_signed && b[WIDTH-1]) b_mag = WIDTH'(-b);
  end

  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          ma_d    = PW'(a_mag);
          mb_d    = b_mag;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mb_q[0]) acc_d = acc_q + ma_q;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        // Sign is applied once to the unsigned magnitude product.
        product_d = neg_q ? PW'(-acc_q) : acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
